// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin request arbiter.
// Optional build macro used by the arbiter: ARB_TIMEOUT_EN.
package arb_pkg;

    localparam int ARB_WIDTH_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest set request at or after ptr,
// wrapping around; found is low when no request is set.
module rr_pick
    import arb_pkg::*;
#(
    parameter int WIDTH = ARB_WIDTH_DEF,
    parameter int IDX_W = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [WIDTH-1:0] rot;
    logic [IDX_W-1:0] off;

    // rotate so ptr lands on bit 0, find lowest set bit, rotate index back
    always_comb begin
        rot = WIDTH'({req, req} >> ptr);
        off = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        found = |req;
        idx   = off + ptr;
    end

endmodule

// File: rtl/req_rr_arbiter.sv
// Round-robin arbiter holding a registered one-hot grant until release.
// Build macro ARB_TIMEOUT_EN adds a forced-release hold timeout.
module req_rr_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH   = ARB_WIDTH_DEF,
    parameter int IDX_W   = idx_w(WIDTH)
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             done,
    output logic [WIDTH-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout_err
);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic             found;
    logic [IDX_W-1:0] pick_idx;
    logic             withdraw;
    logic             to_hit;
    logic             release_now;

    rr_pick #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    logic [TO_W-1:0] cnt;
    assign to_hit = (cnt == TO_W'(TIMEOUT - 1));
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign withdraw    = ~req[grant_idx];
    assign release_now = done | withdraw | to_hit;

    // grant FSM: pick in IDLE, hold until done / withdrawal / timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt         <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant       <= WIDTH'(1) << pick_idx;
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        state       <= HOLD;
`ifdef ARB_TIMEOUT_EN
                        cnt         <= '0;
`endif
                    end
                end
                HOLD: begin
                    if (release_now) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                        ptr         <= grant_idx + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
                        timeout_err <= to_hit & ~done & ~withdraw;
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        cnt <= cnt + TO_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
